// File: rtl/if_stage_pipe_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package if_stage_pipe_pkg;

  // Instruction word the IF/ID register carries when it holds a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int PC_INC = 4;

  // Fetch-stage operating mode.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/if_stage_pipe_pc_reg.sv
// Program counter register with load, hold and sequential increment.
// Latency: new PC visible one edge after load/inc is asserted.
// Backpressure: holds its value whenever neither load nor inc is asserted.
module pc_reg
  import if_stage_pipe_pkg::*;
#(
  parameter int              PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  // Load wins over increment; the increment wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(PC_INC);
    end
  end

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction fetch plus IF/ID register, with post-reset boot hold and stall counter.
// Latency: instruction at imem_addr appears on if_id_* one edge later (non-frozen cycle).
// Backpressure: freeze holds PC and IF/ID; a taken branch overrides freeze and inserts a bubble.
module if_stage_pipe
  import if_stage_pipe_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  BOOT_CYCLES = 2,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic                   booting,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  // Boot counter only needs to reach BOOT_CYCLES-1; keep at least one bit.
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [BW-1:0]         boot_cnt;
  logic [BW-1:0]         boot_cnt_nxt;
  logic                  pc_load;
  logic                  pc_inc;
  logic                  fetch;
  logic                  bubble;
  logic                  stall_inc;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   branch_tgt;

  // Branch targets are word aligned; the low two address bits are dropped.
  assign branch_tgt = branch_addr & ~PC_WIDTH'(3);
  assign pc_plus4   = pc + PC_WIDTH'(PC_INC);
  assign imem_addr  = pc;
  assign booting    = (state == BOOT);

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (branch_tgt),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // State and boot counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
    end
  end

  // Next-state and per-cycle control: BOOT ignores freeze/branch; RUN resolves branch > freeze > fetch.
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    fetch        = 1'b0;
    bubble       = 1'b0;
    stall_inc    = 1'b0;
    case (state)
      BOOT: begin
        bubble = 1'b1;
        if (boot_cnt == BOOT_LAST) begin
          state_nxt    = RUN;
          boot_cnt_nxt = '0;
        end else begin
          boot_cnt_nxt = boot_cnt + BW'(1);
        end
      end
      RUN: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          bubble  = 1'b1;
        end else if (freeze) begin
          stall_inc = 1'b1;
        end else begin
          pc_inc = 1'b1;
          fetch  = 1'b1;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // IF/ID pipeline register: bubble clears it, fetch latches, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      if_id_pc    <= '0;
      if_id_instr <= INSTR_WIDTH'(NOP_INSTR);
      if_id_valid <= 1'b0;
    end else if (fetch) begin
      if_id_pc    <= pc_plus4;
      if_id_instr <= imem_rdata;
      if_id_valid <= 1'b1;
    end
  end

  // Saturating count of cycles in which freeze actually held the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_inc && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule
